// File: rtl/pwm_duty_capture.sv
// pwm_duty_capture: measures an asynchronous PWM waveform one rising edge to the next.
// For each full period it reports the high time, the period length and a 2-bit duty code
// (0..3 quarters, same scale as the heater PWM generator's duty input). A line with no
// rising edge inside the maximum period is reported once as stuck, high or low.
//
// Ports:
//   clk          clock
//   rst_ni       asynchronous active-low reset
//   en_i         measurement enable; low forces idle, results hold
//   pwm_in       asynchronous PWM input
//   valid_o      one-cycle strobe, result outputs updated this cycle
//   period_o     cycles in the last measured period
//   high_o       high cycles in the last measured period
//   duty_code_o  quantized duty, 0..3
//   stuck_o      no rising edge within the maximum period
//   level_o      synchronized input level
module pwm_duty_capture #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             pwm_in,
  output logic             valid_o,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic [1:0]       duty_code_o,
  output logic             stuck_o,
  output logic             level_o
);

  localparam int unsigned DutyW = CNT_W + 2;
  localparam logic [CNT_W-1:0] MaxCnt = {CNT_W{1'b1}};

  typedef enum logic [0:0] {StIdle, StMeasure} state_e;

  state_e           state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             s_d_q;
  logic [CNT_W-1:0] pcnt_q;
  logic [CNT_W-1:0] hcnt_q;

  logic             s;
  logic             rise;
  logic [1:0]       code;

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~s_d_q;
  assign level_o = s;

  // Input synchronizer plus one extra flop for edge detection.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d_q  <= s;
    end
  end

  // Duty quantization: compare 4H against P, 2P and 3P at CNT_W+2 bits so 3P cannot overflow.
  logic [DutyW-1:0] h4, p1, p2, p3;
  always_comb begin
    h4 = {hcnt_q, 2'b00};
    p1 = {2'b00, pcnt_q};
    p2 = {1'b0, pcnt_q, 1'b0};
    p3 = p1 + p2;
    code = 2'd0;
    if (h4 >= p3) begin
      code = 2'd3;
    end else if (h4 >= p2) begin
      code = 2'd2;
    end else if (h4 >= p1) begin
      code = 2'd1;
    end
  end

  // Measurement FSM with registered result outputs.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      pcnt_q      <= '0;
      hcnt_q      <= '0;
      valid_o     <= 1'b0;
      period_o    <= '0;
      high_o      <= '0;
      duty_code_o <= 2'd0;
      stuck_o     <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (!en_i) begin
        // Results and stuck flag hold; any edge this cycle is dropped.
        state_q <= StIdle;
        pcnt_q  <= '0;
        hcnt_q  <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            // First edge only arms; a partial period is never reported.
            if (rise) begin
              state_q <= StMeasure;
              pcnt_q  <= CNT_W'(1);
              hcnt_q  <= CNT_W'(1);
              stuck_o <= 1'b0;
            end
          end
          StMeasure: begin
            if (rise) begin
              valid_o     <= 1'b1;
              period_o    <= pcnt_q;
              high_o      <= hcnt_q;
              duty_code_o <= code;
              // The edge cycle is the first (high) cycle of the next period.
              pcnt_q      <= CNT_W'(1);
              hcnt_q      <= CNT_W'(1);
            end else if (pcnt_q == MaxCnt) begin
              valid_o     <= 1'b1;
              stuck_o     <= 1'b1;
              period_o    <= MaxCnt;
              high_o      <= s ? MaxCnt : '0;
              duty_code_o <= s ? 2'd3 : 2'd0;
              state_q     <= StIdle;
              pcnt_q      <= '0;
              hcnt_q      <= '0;
            end else begin
              pcnt_q <= pcnt_q + CNT_W'(1);
              hcnt_q <= hcnt_q + CNT_W'(s);
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Testbench for pwm_duty_capture. A reference model records the input level sampled at
// every clock edge and derives results from rising-edge timestamps: period is the distance
// between accepted edges, high time is the count of high synchronized samples in between.
module tb_pwm_duty_capture;

  localparam int unsigned CNT_W = 8;
  localparam int SYNC = 2;
  localparam int MAXP = 255;
  localparam int NCYC = 32768;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       en_i = 1'b0;
  logic       pwm_in = 1'b0;
  logic       valid_o;
  logic [7:0] period_o;
  logic [7:0] high_o;
  logic [1:0] duty_code_o;
  logic       stuck_o;
  logic       level_o;

  pwm_duty_capture #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC)
  ) u_dut (
    .clk        (clk),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .pwm_in     (pwm_in),
    .valid_o    (valid_o),
    .period_o   (period_o),
    .high_o     (high_o),
    .duty_code_o(duty_code_o),
    .stuck_o    (stuck_o),
    .level_o    (level_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int strobes = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state.
  bit smp[NCYC];
  int k = 0;
  bit m_armed = 0;
  bit m_valid = 0;
  bit m_stuck = 0;
  int m_t = 0;
  int m_period = 0;
  int m_high = 0;
  int m_code = 0;

  // Synchronized level the measurement logic acts on at edge j.
  function automatic int sync_at(int j);
    if (j >= SYNC && j - SYNC < NCYC) return int'(smp[j-SYNC]);
    return 0;
  endfunction

  function automatic int duty_of(int h, int p);
    if (4 * h >= 3 * p) return 3;
    if (4 * h >= 2 * p) return 2;
    if (4 * h >= p) return 1;
    return 0;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (k < NCYC) begin
        smp[k] = pwm_in;
        if (!rst_ni) begin
          for (int d = 0; d <= SYNC + 1; d++) if (k - d >= 0) smp[k-d] = 1'b0;
          m_armed = 0; m_valid = 0; m_stuck = 0;
          m_period = 0; m_high = 0; m_code = 0;
        end else begin
          bit rise;
          rise = (sync_at(k) == 1) && (sync_at(k - 1) == 0);
          m_valid = 0;
          if (!en_i) begin
            m_armed = 0;
          end else if (!m_armed) begin
            if (rise) begin
              m_armed = 1; m_t = k; m_stuck = 0;
            end
          end else if (rise) begin
            int h;
            h = 0;
            for (int j = m_t; j < k; j++) h += sync_at(j);
            m_period = k - m_t; m_high = h; m_code = duty_of(h, m_period);
            m_valid = 1; m_t = k;
          end else if (k - m_t == MAXP) begin
            m_valid = 1; m_stuck = 1; m_period = MAXP;
            m_high = (sync_at(k) == 1) ? MAXP : 0;
            m_code = (sync_at(k) == 1) ? 3 : 0;
            m_armed = 0;
          end
        end
        #1;
        if (m_valid) strobes++;
        check_val("valid", 32'(valid_o), 32'(m_valid));
        check_val("period", 32'(period_o), 32'(m_period));
        check_val("high", 32'(high_o), 32'(m_high));
        check_val("duty_code", 32'(duty_code_o), 32'(m_code));
        check_val("stuck", 32'(stuck_o), 32'(m_stuck));
        check_val("level", 32'(level_o), 32'((k - SYNC + 1 >= 0) ? int'(smp[k-SYNC+1]) : 0));
        k++;
      end
    end
  end

  task automatic hold(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pwm_in = v;
    end
  endtask

  // n periods of p cycles, first h cycles high; optional enable drop at cycle drop_at.
  task automatic wave(input int p, input int h, input int n, input int drop_at, input int drop_len);
    int c;
    c = 0;
    for (int r = 0; r < n; r++) begin
      for (int i = 0; i < p; i++) begin
        @(negedge clk);
        if (drop_at >= 0 && c == drop_at) en_i = 1'b0;
        if (drop_at >= 0 && c == drop_at + drop_len) en_i = 1'b1;
        pwm_in = (i < h);
        c++;
      end
    end
    en_i = 1'b1;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2 rst_ni = 1'b0;
    #1;
    check_val("rst_valid", 32'(valid_o), 32'd0);
    check_val("rst_period", 32'(period_o), 32'd0);
    check_val("rst_high", 32'(high_o), 32'd0);
    check_val("rst_code", 32'(duty_code_o), 32'd0);
    check_val("rst_stuck", 32'(stuck_o), 32'd0);
    check_val("rst_level", 32'(level_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    int p, h, n, kind;
    en_i = 1'b1;
    hold(0, 3);
    rst_ni = 1'b1;
    hold(0, 3);
    // Generator-style waveforms, period 4.
    wave(4, 1, 6, -1, 0);
    wave(4, 2, 4, -1, 0);
    wave(4, 3, 4, -1, 0);
    // Period 10, half and low duty.
    wave(10, 5, 4, -1, 0);
    wave(10, 2, 4, -1, 0);
    // Stuck low, then recovery without a strobe on the first edge.
    wave(6, 2, 2, -1, 0);
    hold(0, 300);
    wave(5, 2, 3, -1, 0);
    // Stuck high.
    hold(1, 300);
    wave(7, 3, 3, -1, 0);
    // Enable dropped mid-period, then reset mid-measurement.
    wave(10, 3, 5, 23, 6);
    wave(8, 3, 2, -1, 0);
    hold(1, 2);
    reset_pulse();
    wave(8, 3, 3, -1, 0);
    // Randomized segments.
    for (int seg = 0; seg < 30; seg++) begin
      kind = int'($urandom_range(0, 3));
      p = int'($urandom_range(2, 40));
      h = int'($urandom_range(1, p - 1));
      n = int'($urandom_range(1, 5));
      if (kind == 0) begin
        for (int i = 0; i < 60; i++) hold(bit'($urandom_range(0, 1)), 1);
      end else if (kind == 1) begin
        wave(p, h, n + 1, int'($urandom_range(0, p * (n + 1))), int'($urandom_range(1, 8)));
      end else begin
        wave(p, h, n, -1, 0);
      end
    end
    hold(0, 5);
    if (strobes < 20) begin
      failures++;
      $display("FAIL strobe_count: got %0d expected at least 20", strobes);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
